// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: debounce FSM state encoding shared by the conditioner
package button_conditioner_pkg;
  localparam logic [1:0] RELEASED    = 2'd0;
  localparam logic [1:0] PRESS_CNT   = 2'd1;
  localparam logic [1:0] HELD        = 2'd2;
  localparam logic [1:0] RELEASE_CNT = 2'd3;
endpackage

// File: rtl/button_conditioner_sync.sv
// button_conditioner_sync: 2-flop synchronizer for asynchronous pin inputs
module button_conditioner_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] s1_q, s2_q;
  // Two-stage capture; left unreset so the stages flush from the pins during reset
  always_ff @(posedge clk) begin
    s1_q <= d_i;
    s2_q <= s1_q;
  end
  assign q_o = s2_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronize, debounce and edge-detect mechanical inputs
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 2500,
  parameter int PULSE_CNT_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);
  localparam int TW = $clog2(SAMPLE_CNT_MAX);
  localparam int CW = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [TW-1:0] TMAX = TW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0] PMAX = CW'(PULSE_CNT_MAX);
  logic [WIDTH-1:0] sync;
  logic [TW-1:0] t_q;
  logic tick;
  button_conditioner_sync #(.WIDTH(WIDTH)) u_sync (
    .clk(clk),
    .d_i(async_in),
    .q_o(sync)
  );
  assign tick = t_q == TMAX;
  // Free-running sample counter; tick marks the last count before wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) t_q <= '0;
    else        t_q <= tick ? '0 : t_q + 1'b1;
  end
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    logic [1:0] st_q, st_d;
    logic [CW-1:0] c_q, c_d;
    logic s, done, lvl_q, prs_q, rel_q, prs_d, rel_d;
    assign s    = sync[g];
    assign done = c_q + 1'b1 == PMAX;
    // Debounce transitions, evaluated only on sample ticks
    always_comb begin
      st_d = st_q;
      c_d  = c_q;
      if (tick) begin
        case (st_q)
          RELEASED: begin
            st_d = s ? PRESS_CNT : RELEASED;
            c_d  = s ? CW'(1) : '0;
          end
          PRESS_CNT: begin
            st_d = !s ? RELEASED : done ? HELD : PRESS_CNT;
            c_d  = (!s || done) ? '0 : c_q + 1'b1;
          end
          HELD: begin
            st_d = s ? HELD : RELEASE_CNT;
            c_d  = s ? '0 : CW'(1);
          end
          default: begin
            st_d = s ? HELD : done ? RELEASED : RELEASE_CNT;
            c_d  = (s || done) ? '0 : c_q + 1'b1;
          end
        endcase
      end
    end
    assign prs_d = tick && st_q == PRESS_CNT && s && done;
    assign rel_d = tick && st_q == RELEASE_CNT && !s && done;
    // State, counter and registered outputs; level is high in HELD and RELEASE_CNT
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= RELEASED;
        c_q   <= '0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        rel_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        c_q   <= c_d;
        lvl_q <= st_d[1];
        prs_q <= prs_d;
        rel_q <= rel_d;
      end
    end
    assign level[g]         = lvl_q;
    assign press_pulse[g]   = prs_q;
    assign release_pulse[g] = rel_q;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of sync, tick timing and debounce behaviour
module tb_button_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] async_in = 2'b00;
  logic [1:0] level, press_pulse, release_pulse;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  button_conditioner #(.WIDTH(2), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .async_in(async_in),
    .level(level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] l, input logic [1:0] p, input logic [1:0] r);
    chk({tag, ".level"}, 32'(level), 32'(l));
    chk({tag, ".press"}, 32'(press_pulse), 32'(p));
    chk({tag, ".release"}, 32'(release_pulse), 32'(r));
  endtask

  task automatic do_reset(input logic [1:0] a);
    async_in = a;
    rst_n = 1'b0;
    #1;
    chk_out("rst_assert", 2'b00, 2'b00, 2'b00);
    repeat (3) @(negedge clk);
    chk_out("rst_hold", 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    @(negedge clk);
    // pins high through reset: ticks at 4,8,12, press on the third
    do_reset(2'b11);
    run_to(11); chk_out("t1_pre", 2'b00, 2'b00, 2'b00);
    run_to(12); chk_out("t1_press", 2'b11, 2'b11, 2'b00);
    run_to(13); chk_out("t1_after", 2'b11, 2'b00, 2'b00);
    // bounce: high at ticks 4,8, low at tick 12
    do_reset(2'b00);
    async_in = 2'b01;
    run_to(9); async_in = 2'b00;
    run_to(12); chk_out("t3_bounce", 2'b00, 2'b00, 2'b00);
    run_to(13); chk_out("t3_after", 2'b00, 2'b00, 2'b00);
    // clean press: ticks 16,20,24 must all be needed, proving RELEASED restart
    async_in = 2'b01;
    run_to(20); chk_out("t2_mid", 2'b00, 2'b00, 2'b00);
    run_to(23); chk_out("t2_pre", 2'b00, 2'b00, 2'b00);
    run_to(24); chk_out("t2_press", 2'b01, 2'b01, 2'b00);
    run_to(25); chk_out("t2_after", 2'b01, 2'b00, 2'b00);
    // one-tick low glitch at tick 28, high again at 32
    async_in = 2'b00;
    run_to(29); chk_out("t4_glitch", 2'b01, 2'b00, 2'b00);
    async_in = 2'b01;
    run_to(33); chk_out("t4_glitch_end", 2'b01, 2'b00, 2'b00);
    // real release: low at ticks 36,40,44
    async_in = 2'b00;
    run_to(40); chk_out("t4_mid", 2'b01, 2'b00, 2'b00);
    run_to(43); chk_out("t4_pre", 2'b01, 2'b00, 2'b00);
    run_to(44); chk_out("t4_release", 2'b00, 2'b00, 2'b01);
    run_to(45); chk_out("t4_after", 2'b00, 2'b00, 2'b00);
    // both bits together: ticks 48,52,56
    async_in = 2'b11;
    run_to(55); chk_out("t5_pre", 2'b00, 2'b00, 2'b00);
    run_to(56); chk_out("t5_press", 2'b11, 2'b11, 2'b00);
    run_to(57); chk_out("t5_after", 2'b11, 2'b00, 2'b00);
    // async reset while HELD drops level without a clock edge
    rst_n = 1'b0;
    #1; chk("t6_held_rst.level", 32'(level), 32'(2'b00));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    // reset again mid-PRESS_CNT (after ticks 4,8)
    run_to(9);
    rst_n = 1'b0;
    #1; chk_out("t6_cnt_rst", 2'b00, 2'b00, 2'b00);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    run_to(8); chk_out("t6_no_early", 2'b00, 2'b00, 2'b00);
    run_to(11); chk_out("t6_pre", 2'b00, 2'b00, 2'b00);
    run_to(12); chk_out("t6_press", 2'b11, 2'b11, 2'b00);
    run_to(13); chk_out("t6_after", 2'b11, 2'b00, 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Conditions WIDTH asynchronous mechanical inputs (buttons, switches) for the single-clock core. Each bit passes through a 2-flop synchronizer and then a shared-tick debounce FSM. The block emits a clean level plus one-cycle press and release pulses per bit. It sits between the board I/O pins and the MMIO and user-logic consumers.

Parameters:
WIDTH, 1, number of independent input bits
SAMPLE_CNT_MAX, 2500, clk cycles between debounce sample ticks; must be >= 2
PULSE_CNT_MAX, 200, consecutive agreeing ticks required to change a debounced level; must be >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
async_in  input  WIDTH  raw pin inputs, no timing relation to clk
level  output  WIDTH  debounced level per bit
press_pulse  output  WIDTH  one-cycle pulse on debounced 0->1
release_pulse  output  WIDTH  one-cycle pulse on debounced 1->0

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0, level, press_pulse and release_pulse = 0, the tick counter = 0, every bit FSM = RELEASED and every debounce counter = 0. The synchronizer flops are not reset.
- Synchronizer: fixed 2-cycle latency from async_in to the internal sync bit.
- Tick generator:
  - Counter counts 0..SAMPLE_CNT_MAX-1 and wraps to 0.
  - tick = 1 for one cycle when the count equals SAMPLE_CNT_MAX-1.
  - The first tick after reset comes SAMPLE_CNT_MAX cycles after rst_n rises. Because SAMPLE_CNT_MAX >= 2, the unreset synchronizer stages are flushed before they are first sampled.
- Per-bit FSM: all state changes occur only at a tick edge. Debounce counter width is $clog2(PULSE_CNT_MAX+1).
  - RELEASED:
    - tick & sync=1 -> PRESS_CNT, cnt=1
    - otherwise hold, cnt=0
  - PRESS_CNT:
    - tick & sync=1 & cnt+1==PULSE_CNT_MAX -> HELD, cnt=0, press_pulse=1 next cycle
    - tick & sync=1 otherwise -> cnt+1
    - tick & sync=0 -> RELEASED, cnt=0 (bounce rejected, no pulse)
  - HELD:
    - tick & sync=0 -> RELEASE_CNT, cnt=1
  - RELEASE_CNT:
    - tick & sync=0 & cnt+1==PULSE_CNT_MAX -> RELEASED, cnt=0, release_pulse=1 next cycle
    - tick & sync=0 otherwise -> cnt+1
    - tick & sync=1 -> HELD, cnt=0 (no pulse)
- Outputs:
  - level is registered: 1 in HELD and RELEASE_CNT, 0 in RELEASED and PRESS_CNT. level changes in the same cycle that the matching pulse is high.
  - Pulses are registered and high for exactly one clk cycle. Press and release never assert together on one bit. Between ticks, pulses return to 0.
- Sync changes between ticks are ignored; only the value on tick cycles counts.
- Total press latency from a stable pin change is at most 2 + SAMPLE_CNT_MAX*PULSE_CNT_MAX + 1 cycles.
- Bits are fully independent and share only the tick. Several bits may pulse in the same cycle.
- Reset mid-count or while HELD: outputs drop to 0 immediately and asynchronously, and the FSM restarts from RELEASED.
- Counters never exceed PULSE_CNT_MAX-1. There is no wrap in FSM counters.

Decomposition:
- Shared package: 2-bit FSM state encoding (RELEASED=0, PRESS_CNT=1, HELD=2, RELEASE_CNT=3). No other shared constants.
- Sub-modules:
  - Instantiate the existing synchronizer module with width=WIDTH for the front end.
  - Per-bit logic goes in a generate loop, or optionally in a debounce_fsm sub-module (one bit, shared tick input).
  - The tick counter stays in the top module.

Test Plan:
(Bench parameters: WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3.)
1. Reset: hold rst_n=0 with async_in=2'b11 -> all outputs 0. Release rst_n: first tick at cycle 4, and no pulse before 3 ticks of high sync.
2. Clean press on bit0: async_in[0]=1 held -> press_pulse[0] high for exactly 1 cycle and level[0]=1 from the cycle after the 3rd high tick. Bit1 stays 0 throughout.
3. Bounce on bit0: high for 2 ticks, low at the 3rd tick -> no press_pulse, level stays 0, FSM returns to RELEASED.
4. Release: from HELD, drive 0 for 3 ticks -> release_pulse[0] one cycle and level[0]=0. A 1-tick low glitch while HELD produces no pulse and level stays 1.
5. Simultaneous: both bits rise in the same cycle -> press_pulse=2'b11 in the same single cycle.
6. Async reset: pulse rst_n low mid-PRESS_CNT and while HELD -> level=0 combinationally with rst_n low. After release, a full 3-tick press is required before press_pulse.
